quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Receiver-side decoder for the 2-bit Gray-coded state stream driven by a Moore sequencer.
- Samples the 2-bit code every enabled cycle and classifies each change as a forward step, a reverse step, or an illegal jump.
- Maintains a wrapping position count and a last-direction flag.
- Raises a sticky error on illegal jumps and holds it until software clears it.

Parameters:
- W, 8, width of the position counter pos.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when low the decoder freezes.
- clr  input  1  synchronous clear of fault/tracking; single-cycle pulse.
- code  input  2  Gray-coded state from the sequencer.
- step_fwd  output  1  one-cycle pulse per forward step.
- step_rev  output  1  one-cycle pulse per reverse step.
- dir  output  1  direction of last valid step (1 = forward).
- pos  output  W  signed-agnostic step count, wraps mod 2^W.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (rst=0, asynchronous): state=INIT, prev=2'b00, pos=0, dir=0, err=0, step_fwd=0, step_rev=0. Release is synchronous to the next rising edge.
- Forward Gray cycle: 00 -> 01 -> 11 -> 10 -> 00. Reverse is the opposite order. A two-bit change (00<->11, 01<->10) is illegal.
- All outputs are registered. The classification uses code at rising edge N against prev. The result appears on outputs from edge N until edge N+1. Latency is 1 cycle from sampled code to pulse/pos.
- State INIT:
  - On an edge with en=1: prev<=code, go to TRACK.
  - No pulse; pos unchanged.
- State TRACK (en=1):
  - code==prev: hold, no pulse.
  - Forward successor: step_fwd=1, pos<=pos+1, dir<=1, prev<=code.
  - Reverse successor: step_rev=1, pos<=pos-1, dir<=0, prev<=code.
  - Illegal: err<=1, go to FAULT, pos/dir unchanged, prev<=code.
- State FAULT:
  - err stays 1 and no pulses occur.
  - prev still tracks code on en=1 cycles.
  - pos is frozen.
- clr=1 at an edge, in any state: err<=0, state<=INIT, pulses 0. pos and dir are NOT cleared.
- clr has priority over en and over any transition in the same cycle.
- en=0: no sampling, prev held, pulses 0, state held. clr still acts.
- Wrap-around: pos at 2^W-1 plus a forward step gives 0. pos at 0 plus a reverse step gives 2^W-1. There is no saturation and no error on wrap.
- step_fwd and step_rev are mutually exclusive and never high for two consecutive cycles unless code changes on consecutive enabled edges.
- Reset mid-operation forces all outputs to reset values immediately, without waiting for clk.

Test Plan:
- Reset 0->1, en=1, code held 00 for 4 edges -> INIT then TRACK; pos=0, no pulses, err=0.
- code 00,01,11,10,00 on successive enabled edges -> four step_fwd pulses each 1 cycle wide; pos=4, dir=1.
- From pos=4, code 00,10,11 -> two step_rev pulses; pos=2, dir=0.
- Wrap test with W=8:
  - From pos=0, one reverse step -> pos=8'hFF.
  - From pos=8'hFF, one forward step -> pos=8'h00.
- Illegal jump at prev=01, code=10:
  - Next cycle err=1, no pulse, pos unchanged.
  - Further legal steps are ignored.
  - A clr pulse gives err=0 next cycle and INIT.
  - The next enabled edge resyncs with no pulse, then steps resume.
- en=0 while code walks 00->01->11 -> no pulses, pos unchanged. Raising en with code=11 against prev=00 -> illegal, err=1.
- Async check: rst driven low mid-cycle while step_fwd=1 -> step_fwd, err, pos drop to 0 before the next clk edge.

Source files
------------

// File: rtl/quad_step_decoder.sv
// Purpose: decode a 2-bit Gray-coded sequencer state stream into forward and
//          reverse step pulses, a wrapping position count and a direction flag.
// Latency: 1 cycle from the sampled code to the pulse and position update.
// Backpressure: none; en=0 freezes decoding, clr resyncs and clears the fault.
//
// Ports:
//   clk      rising-edge system clock
//   rst      asynchronous active-low reset
//   en       sample enable; low freezes all tracking state
//   clr      synchronous clear of err, returning to resync (pos/dir kept)
//   code     2-bit Gray code from the sequencer
//   step_fwd one-cycle pulse per forward step
//   step_rev one-cycle pulse per reverse step
//   dir      direction of the last valid step (1 = forward)
//   pos      step count, wraps mod 2^W
//   err      sticky illegal-transition flag
module quad_step_decoder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [1:0]   code,
  output logic         step_fwd,
  output logic         step_rev,
  output logic         dir,
  output logic [W-1:0] pos,
  output logic         err
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  localparam logic [W-1:0] POS_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [1:0] prev;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_of(input logic [1:0] c);
    logic [1:0] r;
    r = 2'b00;
    case (c)
      2'b00: r = 2'b01;
      2'b01: r = 2'b11;
      2'b11: r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] c);
    logic [1:0] r;
    r = 2'b00;
    case (c)
      2'b00: r = 2'b10;
      2'b10: r = 2'b11;
      2'b11: r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      prev     <= 2'b00;
      pos      <= '0;
      dir      <= 1'b0;
      err      <= 1'b0;
      step_fwd <= 1'b0;
      step_rev <= 1'b0;
    end else begin
      // Pulses are single-cycle by construction: cleared unless re-asserted.
      step_fwd <= 1'b0;
      step_rev <= 1'b0;
      if (clr) begin
        // clr outranks en and any pending transition this cycle.
        err   <= 1'b0;
        state <= ST_INIT;
      end else if (en) begin
        case (state)
          ST_INIT: begin
            // Resync: take the current code as the reference, no step.
            prev  <= code;
            state <= ST_TRACK;
          end
          ST_TRACK: begin
            if (code == prev) begin
              // hold
            end else if (code == fwd_of(prev)) begin
              step_fwd <= 1'b1;
              pos      <= pos + POS_ONE;
              dir      <= 1'b1;
              prev     <= code;
            end else if (code == rev_of(prev)) begin
              step_rev <= 1'b1;
              pos      <= pos - POS_ONE;
              dir      <= 1'b0;
              prev     <= code;
            end else begin
              // Both bits changed: direction unknowable, so flag and freeze.
              err   <= 1'b1;
              state <= ST_FAULT;
              prev  <= code;
            end
          end
          ST_FAULT: begin
            // Keep following the code so a later clr resyncs cleanly.
            prev <= code;
          end
          default: begin
            state <= ST_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Purpose: directed self-checking bench for quad_step_decoder (W=8).
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_quad_step_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [1:0] code;
  logic       step_fwd;
  logic       step_rev;
  logic       dir;
  logic [7:0] pos;
  logic       err;

  int n_cmp;
  int n_bad;

  quad_step_decoder #(.W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .code     (code),
    .step_fwd (step_fwd),
    .step_rev (step_rev),
    .dir      (dir),
    .pos      (pos),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] code;
    logic       fwd;
    logic       rev;
    logic       dir;
    logic [7:0] pos;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [11:0] want);
    logic [11:0] got;
    got = {step_fwd, step_rev, dir, pos, err};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got fwd/rev/dir/pos/err=%b/%b/%b/%h/%b want %b/%b/%b/%h/%b",
               name, got[11], got[10], got[9], got[8:1], got[0],
               want[11], want[10], want[9], want[8:1], want[0]);
    end
  endtask

  task automatic add(input logic e, input logic c, input logic [1:0] cd,
                     input logic f, input logic r, input logic d,
                     input logic [7:0] p, input logic er);
    vec_t v;
    v.en = e; v.clr = c; v.code = cd;
    v.fwd = f; v.rev = r; v.dir = d; v.pos = p; v.err = er;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //   en clr code   fwd rev dir pos    err
    // resync then hold at 00 for four edges
    add(1, 0, 2'b00,  0, 0, 0, 8'h00, 0);
    add(1, 0, 2'b00,  0, 0, 0, 8'h00, 0);
    add(1, 0, 2'b00,  0, 0, 0, 8'h00, 0);
    add(1, 0, 2'b00,  0, 0, 0, 8'h00, 0);
    // forward cycle
    add(1, 0, 2'b01,  1, 0, 1, 8'h01, 0);
    add(1, 0, 2'b11,  1, 0, 1, 8'h02, 0);
    add(1, 0, 2'b10,  1, 0, 1, 8'h03, 0);
    add(1, 0, 2'b00,  1, 0, 1, 8'h04, 0);
    add(1, 0, 2'b00,  0, 0, 1, 8'h04, 0);
    // reverse steps down through zero
    add(1, 0, 2'b10,  0, 1, 0, 8'h03, 0);
    add(1, 0, 2'b11,  0, 1, 0, 8'h02, 0);
    add(1, 0, 2'b01,  0, 1, 0, 8'h01, 0);
    add(1, 0, 2'b00,  0, 1, 0, 8'h00, 0);
    add(1, 0, 2'b10,  0, 1, 0, 8'hFF, 0);
    add(1, 0, 2'b00,  1, 0, 1, 8'h00, 0);
    // illegal jump 01 -> 10, legal steps ignored, clr, resync, resume
    add(1, 0, 2'b01,  1, 0, 1, 8'h01, 0);
    add(1, 0, 2'b10,  0, 0, 1, 8'h01, 1);
    add(1, 0, 2'b00,  0, 0, 1, 8'h01, 1);
    add(1, 0, 2'b01,  0, 0, 1, 8'h01, 1);
    add(1, 1, 2'b11,  0, 0, 1, 8'h01, 0);
    add(1, 0, 2'b11,  0, 0, 1, 8'h01, 0);
    add(1, 0, 2'b10,  1, 0, 1, 8'h02, 0);
    // en low while code walks, then enable on an illegal code
    add(1, 0, 2'b00,  1, 0, 1, 8'h03, 0);
    add(0, 0, 2'b01,  0, 0, 1, 8'h03, 0);
    add(0, 0, 2'b11,  0, 0, 1, 8'h03, 0);
    add(1, 0, 2'b11,  0, 0, 1, 8'h03, 1);
    // clr with en low still acts
    add(0, 1, 2'b11,  0, 0, 1, 8'h03, 0);
    add(1, 0, 2'b11,  0, 0, 1, 8'h03, 0);
    add(1, 0, 2'b01,  0, 1, 0, 8'h02, 0);
    add(1, 0, 2'b00,  0, 1, 0, 8'h01, 0);
    // clr outranks a legal forward step in the same cycle
    add(1, 1, 2'b01,  0, 0, 0, 8'h01, 0);
    add(1, 0, 2'b01,  0, 0, 0, 8'h01, 0);
    add(1, 0, 2'b11,  1, 0, 1, 8'h02, 0);

    // Asynchronous reset before the first clock edge.
    rst  = 1'b1;
    en   = 1'b0;
    clr  = 1'b0;
    code = 2'b00;
    #2;
    rst = 1'b0;
    #1;
    check("reset_async", 12'h000);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_held", 12'h000);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en   = vecs[i].en;
      clr  = vecs[i].clr;
      code = vecs[i].code;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {vecs[i].fwd, vecs[i].rev, vecs[i].dir, vecs[i].pos, vecs[i].err});
    end

    // Mid-cycle reset while step_fwd is high (last vector left it set).
    #2;
    rst = 1'b0;
    #1;
    check("reset_midcycle", 12'h000);
    en  = 1'b1;
    code = 2'b10;
    @(posedge clk);
    #1;
    check("reset_hold_edge", 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
